mod_port: RTL and testbench
===========================

MOD_PORT -- requirements
Module: mod_port

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, word capacity of the internal packet FIFO (power of two, >=8).
REQ-002 clk_156m25  input  1  sole clock; all logic on rising edge.
REQ-003 reset_156m25  input  1  reset, asynchronous, active-high.
REQ-004 pkt_tx_data  input  64  transmit word.
REQ-005 pkt_tx_val  input  1  transmit word valid.
REQ-006 pkt_tx_sop  input  1  first word of packet (qualified by val).
REQ-007 pkt_tx_eop  input  1  last word of packet (qualified by val).
REQ-008 pkt_tx_mod  input  3  valid bytes in eop word; 0 = all 8.
REQ-009 pkt_tx_full  output  1  FIFO almost full; source should stop after current word.
REQ-010 pkt_rx_ren  input  1  read request.
REQ-011 pkt_rx_avail  output  1  at least one complete packet stored.
REQ-012 pkt_rx_data  output  64  received word.
REQ-013 pkt_rx_val  output  1  received word valid.
REQ-014 pkt_rx_sop / pkt_rx_eop  output  1 each  packet delimiters.
REQ-015 pkt_rx_mod  output  3  byte count on eop word, 0 on other words.
REQ-016 pkt_rx_err  output  1  packet errored; asserted only on eop word.

Function
REQ-017 Block SHALL be a store-and-forward packet loopback: accepted TX words leave on RX in order, data/sop/eop/mod unchanged.
REQ-018 Each FIFO entry SHALL hold {data, sop, eop, mod, err}.
REQ-019 TX tracker SHALL have states IDLE and IN_PKT (and DROP); val&sop in IDLE -> IN_PKT; val&eop in IN_PKT -> IDLE; single word sop&eop stays IDLE.
REQ-020 In IDLE, val without sop SHALL be discarded silently.
REQ-021 Non-eop words SHALL be written only while count < FIFO_DEPTH-1; eop words while count < FIFO_DEPTH (last entry reserved for eop).
REQ-022 A non-eop word failing REQ-021 in IN_PKT SHALL move to DROP: words discarded until eop, which is written with err=1, mod kept.
REQ-023 A sop word failing REQ-021 SHALL discard the whole packet silently (nothing written, no avail change).
REQ-024 val&sop while IN_PKT SHALL be written as eop with err=1, mod=0, terminating the open packet; words then discarded until the next sop.
REQ-025 pkt_tx_full SHALL be registered, high when count >= FIFO_DEPTH-2.
REQ-026 Complete-packet counter SHALL increment on eop write, decrement on eop read, unchanged on both in one cycle.
REQ-027 pkt_rx_avail SHALL be registered from counter != 0; first high the cycle after eop write.
REQ-028 A read SHALL occur when pkt_rx_ren=1 and counter != 0; otherwise no read, ren ignored.
REQ-029 Read latency SHALL be one cycle: ren sampled cycle M -> val and word fields at cycle M+1.
REQ-030 When val=0, rx data/sop/eop/mod/err SHALL hold 0.
REQ-031 Simultaneous write and read SHALL both complete; count unchanged.

Reset
REQ-032 Reset SHALL clear FIFO pointers, count, packet counter, tracker to IDLE; pkt_tx_full, pkt_rx_avail, pkt_rx_val, sop, eop, err = 0, data = 0, mod = 0.
REQ-033 Reset mid-packet SHALL discard all stored and partial packets; no output word after release until new complete packet.

Structure
REQ-034 Package mod_port_pkg SHALL hold DATA_W=64, MOD_W=3, default FIFO_DEPTH and the packed FIFO-entry struct.
REQ-035 Storage SHALL be one sub-module sync_fifo (single clock, count output); framing/drop logic and rx output register in mod_port.

Verification
REQ-036 3-word packet (sop data 0x11.., 0x22.., eop 0x33.. mod=5), ren held 1 -> avail next cycle after eop, 3 rx words, rx_mod=5 on eop, err=0.
REQ-037 Single word sop&eop, mod=0 -> one rx word with sop=eop=1, mod=0.
REQ-038 20-word packet, ren=0, depth 16 -> full at count 14, words 16-19 dropped, eop stored err=1; 16 entries read out.
REQ-039 sop, data, sop (no eop) -> 3rd word read as eop err=1 mod=0; following words until next sop absent.
REQ-040 ren=1 with empty FIFO -> val stays 0; val-only word in IDLE -> nothing stored.
REQ-041 Reset asserted after 2 words of 4 -> all outputs 0, avail stays 0 after release.

Source files
------------

// File: rtl/mod_port_pkg.sv
// Shared types and widths for the mod_port store-and-forward packet loopback.
package mod_port_pkg;

  localparam int unsigned DATA_W         = 64;
  localparam int unsigned MOD_W          = 3;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [MOD_W-1:0]  mod;
    logic              err;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_PKT,
    ST_DROP
  } tx_state_e;

endpackage

// File: rtl/mod_port_if.sv
// Packet TX/RX bus of mod_port; slave is the loopback, master is the packet source/sink.
interface mod_port_if;
  import mod_port_pkg::*;

  logic [DATA_W-1:0] pkt_tx_data;
  logic              pkt_tx_val;
  logic              pkt_tx_sop;
  logic              pkt_tx_eop;
  logic [MOD_W-1:0]  pkt_tx_mod;
  logic              pkt_tx_full;
  logic              pkt_rx_ren;
  logic              pkt_rx_avail;
  logic [DATA_W-1:0] pkt_rx_data;
  logic              pkt_rx_val;
  logic              pkt_rx_sop;
  logic              pkt_rx_eop;
  logic [MOD_W-1:0]  pkt_rx_mod;
  logic              pkt_rx_err;

  modport slave (
    input  pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_rx_ren,
    output pkt_tx_full, pkt_rx_avail, pkt_rx_data, pkt_rx_val, pkt_rx_sop,
           pkt_rx_eop, pkt_rx_mod, pkt_rx_err
  );

  modport master (
    output pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_rx_ren,
    input  pkt_tx_full, pkt_rx_avail, pkt_rx_data, pkt_rx_val, pkt_rx_sop,
           pkt_rx_eop, pkt_rx_mod, pkt_rx_err
  );

endinterface

// File: rtl/mod_port_sync_fifo.sv
// Single-clock FIFO of packet entries; read data is the head entry (show-ahead).
module sync_fifo
  import mod_port_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  fifo_entry_t   wr_data_i,
  input  logic          rd_en_i,
  output fifo_entry_t   rd_data_o,
  output logic [CW-1:0] count_o
);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          rd_ok;

  assign rd_ok     = rd_en_i && (count_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en_i, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mod_port.sv
// Store-and-forward packet loopback: TX framing/drop tracker, packet FIFO, registered RX port.
module mod_port
  import mod_port_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25,
  mod_port_if.slave   bus
);

  localparam int unsigned   CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LIM_EOP  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LIM_DATA = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] LIM_FULL = CW'(FIFO_DEPTH - 2);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          wr_en, rd_en;
  fifo_entry_t   wr_entry, rd_entry;
  logic          room_data, room_eop;
  logic          full_q, avail_q, rx_val_q;
  fifo_entry_t   rx_q;

  // Last FIFO slot is kept for an eop so an accepted packet can always be closed.
  assign room_data = fifo_count < LIM_DATA;
  assign room_eop  = fifo_count < LIM_EOP;
  assign rd_en     = bus.pkt_rx_ren && (pkt_cnt_q != '0);

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.pkt_tx_val) begin
      unique case (state_q)
        ST_IDLE:   if (bus.pkt_tx_sop && !bus.pkt_tx_eop && room_data) state_d = ST_IN_PKT;
        ST_IN_PKT: begin
          if (bus.pkt_tx_sop || bus.pkt_tx_eop) state_d = ST_IDLE;
          else if (!room_data)                  state_d = ST_DROP;
        end
        ST_DROP:   if (bus.pkt_tx_sop || bus.pkt_tx_eop) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // A sop inside an open packet closes it as an errored eop; later words wait for a new sop.
  always_comb begin
    wr_en         = 1'b0;
    wr_entry.data = bus.pkt_tx_data;
    wr_entry.sop  = bus.pkt_tx_sop;
    wr_entry.eop  = bus.pkt_tx_eop;
    wr_entry.mod  = bus.pkt_tx_eop ? bus.pkt_tx_mod : '0;
    wr_entry.err  = 1'b0;
    if (bus.pkt_tx_val) begin
      unique case (state_q)
        ST_IDLE: if (bus.pkt_tx_sop) wr_en = bus.pkt_tx_eop ? room_eop : room_data;
        ST_IN_PKT, ST_DROP: begin
          if (bus.pkt_tx_sop) begin
            wr_en        = room_eop;
            wr_entry.sop = 1'b0;
            wr_entry.eop = 1'b1;
            wr_entry.mod = '0;
            wr_entry.err = 1'b1;
          end else if (bus.pkt_tx_eop) begin
            wr_en        = room_eop;
            wr_entry.err = (state_q == ST_DROP);
          end else begin
            wr_en = (state_q == ST_IN_PKT) && room_data;
          end
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    unique case ({wr_en && wr_entry.eop, rd_en && rd_entry.eop})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    count_next = fifo_count;
    unique case ({wr_en, rd_en})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_156m25),
    .rst_i     (reset_156m25),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_entry),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_entry),
    .count_o   (fifo_count)
  );

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      pkt_cnt_q <= '0;
      full_q    <= 1'b0;
      avail_q   <= 1'b0;
      rx_val_q  <= 1'b0;
      rx_q      <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      full_q    <= count_next >= LIM_FULL;
      avail_q   <= pkt_cnt_d != '0;
      rx_val_q  <= rd_en;
      rx_q      <= rd_en ? rd_entry : '0;
    end
  end

  assign bus.pkt_tx_full  = full_q;
  assign bus.pkt_rx_avail = avail_q;
  assign bus.pkt_rx_val   = rx_val_q;
  assign bus.pkt_rx_data  = rx_q.data;
  assign bus.pkt_rx_sop   = rx_q.sop;
  assign bus.pkt_rx_eop   = rx_q.eop;
  assign bus.pkt_rx_mod   = rx_q.mod;
  assign bus.pkt_rx_err   = rx_q.err;

endmodule

// File: tb/tb_mod_port.sv
// Scoreboard bench for mod_port: directed packets push expected RX words, a monitor pops and compares.
module tb_mod_port;
  import mod_port_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  fifo_entry_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_port_if bus ();

  mod_port #(.FIFO_DEPTH(16)) dut (
    .clk_156m25   (clk),
    .reset_156m25 (rst),
    .bus          (bus)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic s, input logic e,
                      input logic [2:0] m, input logic er);
    fifo_entry_t x;
    x.data = d; x.sop = s; x.eop = e; x.mod = m; x.err = er;
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
    @(posedge clk); #1;
    bus.pkt_tx_val  = 1'b1;
    bus.pkt_tx_data = d;
    bus.pkt_tx_sop  = s;
    bus.pkt_tx_eop  = e;
    bus.pkt_tx_mod  = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.pkt_tx_val  = 1'b0;
      bus.pkt_tx_data = '0;
      bus.pkt_tx_sop  = 1'b0;
      bus.pkt_tx_eop  = 1'b0;
      bus.pkt_tx_mod  = '0;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: actual %0d words outstanding required 0", name, exp_q.size());
    end
    idle(3);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_full"},  72'(bus.pkt_tx_full),  72'(0));
    check({name, "_avail"}, 72'(bus.pkt_rx_avail), 72'(0));
    check({name, "_rxword"},
          {bus.pkt_rx_val, bus.pkt_rx_data, bus.pkt_rx_sop, bus.pkt_rx_eop,
           bus.pkt_rx_mod, bus.pkt_rx_err}, 72'(0));
  endtask

  always @(negedge clk) begin : monitor
    fifo_entry_t e;
    if (bus.pkt_rx_val === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: actual word %0h required no word", bus.pkt_rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 72'(bus.pkt_rx_data), 72'(e.data));
        check("rx_flags", {bus.pkt_rx_sop, bus.pkt_rx_eop, bus.pkt_rx_mod, bus.pkt_rx_err},
              {e.sop, e.eop, e.mod, e.err});
      end
    end else begin
      check("rx_idle_zero",
            {bus.pkt_rx_val, bus.pkt_rx_data, bus.pkt_rx_sop, bus.pkt_rx_eop,
             bus.pkt_rx_mod, bus.pkt_rx_err}, 72'(0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.pkt_rx_ren  = 1'b0;
    bus.pkt_tx_val  = 1'b0;
    bus.pkt_tx_data = '0;
    bus.pkt_tx_sop  = 1'b0;
    bus.pkt_tx_eop  = 1'b0;
    bus.pkt_tx_mod  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // read request with nothing stored, then a val-only word in IDLE
    bus.pkt_rx_ren = 1'b1;
    idle(4);
    check("empty_ren_val", 72'(bus.pkt_rx_val), 72'(0));
    drive(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0, 3'd0);
    idle(3);
    check("orphan_avail", 72'(bus.pkt_rx_avail), 72'(0));

    // 3-word packet, ren held high; middle word mod must read back as 0
    drive(64'h1111_1111_1111_1111, 1'b1, 1'b0, 3'd0);
    push (64'h1111_1111_1111_1111, 1'b1, 1'b0, 3'd0, 1'b0);
    drive(64'h2222_2222_2222_2222, 1'b0, 1'b0, 3'd3);
    push (64'h2222_2222_2222_2222, 1'b0, 1'b0, 3'd0, 1'b0);
    drive(64'h3333_3333_3333_3333, 1'b0, 1'b1, 3'd5);
    push (64'h3333_3333_3333_3333, 1'b0, 1'b1, 3'd5, 1'b0);
    check("avail_before_eop", 72'(bus.pkt_rx_avail), 72'(0));
    idle(1);
    check("avail_after_eop", 72'(bus.pkt_rx_avail), 72'(1));
    wait_drain("drain_3word", 20);

    // single-word packet
    drive(64'h4444_4444_4444_4444, 1'b1, 1'b1, 3'd0);
    push (64'h4444_4444_4444_4444, 1'b1, 1'b1, 3'd0, 1'b0);
    idle(1);
    wait_drain("drain_single", 20);

    // sop inside an open packet terminates it; orphan words until next sop vanish
    drive(64'h5555_0000_0000_0001, 1'b1, 1'b0, 3'd0);
    push (64'h5555_0000_0000_0001, 1'b1, 1'b0, 3'd0, 1'b0);
    drive(64'h5555_0000_0000_0002, 1'b0, 1'b0, 3'd0);
    push (64'h5555_0000_0000_0002, 1'b0, 1'b0, 3'd0, 1'b0);
    drive(64'h5555_0000_0000_0003, 1'b1, 1'b0, 3'd6);
    push (64'h5555_0000_0000_0003, 1'b0, 1'b1, 3'd0, 1'b1);
    drive(64'h5555_0000_0000_0004, 1'b0, 1'b0, 3'd0);
    drive(64'h5555_0000_0000_0005, 1'b0, 1'b1, 3'd2);
    drive(64'h6666_6666_6666_6666, 1'b1, 1'b1, 3'd4);
    push (64'h6666_6666_6666_6666, 1'b1, 1'b1, 3'd4, 1'b0);
    idle(1);
    wait_drain("drain_resop", 40);

    // 20-word packet into a 16-deep FIFO with reads stalled
    bus.pkt_rx_ren = 1'b0;
    idle(1);
    for (int k = 1; k <= 20; k++) begin
      logic [63:0] d;
      int stored;
      d = 64'h3800_0000_0000_0000 | 64'(k);
      drive(d, k == 1, k == 20, (k == 20) ? 3'd7 : 3'd0);
      stored = (k - 1 > 15) ? 15 : k - 1;
      if (k >= 12 && k <= 17) check("full_level", 72'(bus.pkt_tx_full), 72'(stored >= 14));
      if (k <= 15)  push(d, k == 1, 1'b0, 3'd0, 1'b0);
      if (k == 20)  push(d, 1'b0, 1'b1, 3'd7, 1'b1);
    end
    idle(1);
    check("overflow_avail", 72'(bus.pkt_rx_avail), 72'(1));
    check("overflow_full", 72'(bus.pkt_tx_full), 72'(1));
    bus.pkt_rx_ren = 1'b1;
    wait_drain("drain_overflow", 60);
    check("full_after_drain", 72'(bus.pkt_tx_full), 72'(0));

    // reset in the middle of a 4-word packet
    bus.pkt_rx_ren = 1'b0;
    drive(64'h7777_0000_0000_0001, 1'b1, 1'b0, 3'd0);
    drive(64'h7777_0000_0000_0002, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    bus.pkt_tx_val = 1'b0;
    rst = 1'b1;
    #2;
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pkt_rx_ren = 1'b1;
    drive(64'h7777_0000_0000_0003, 1'b0, 1'b0, 3'd0);
    drive(64'h7777_0000_0000_0004, 1'b0, 1'b1, 3'd1);
    idle(5);
    check("post_reset_avail", 72'(bus.pkt_rx_avail), 72'(0));
    check("post_reset_val", 72'(bus.pkt_rx_val), 72'(0));
    drive(64'h8888_8888_8888_8888, 1'b1, 1'b1, 3'd2);
    push (64'h8888_8888_8888_8888, 1'b1, 1'b1, 3'd2, 1'b0);
    idle(1);
    wait_drain("drain_recover", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
